// File: rtl/lifo_stack_param.sv
// Parametrised LIFO stack with replace-top (push+pop), peek, occupancy count,
// almost-full flag, synchronous flush and single-cycle overflow/underflow pulses.
// count is the only pointer; all flags are decoded from it.
module lifo_stack_param #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 8,
  parameter int AFULL_LEVEL = 6,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  pop_valid,
  output logic [DATA_WIDTH-1:0] top_data,
  output logic [CW-1:0]         count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow
);

  // Storage index width; DEPTH >= 2 keeps this at least one bit.
  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] stack [DEPTH];
  logic [AW-1:0]         top_idx;
  logic [AW-1:0]         wr_idx;
  logic                  wr_en;

  assign empty       = (count == '0);
  assign full        = (count == CW'(DEPTH));
  assign almost_full = (count >= CW'(AFULL_LEVEL));

  // Index of the current top entry and of the slot a push would land in.
  // top_idx is only meaningful when the stack is not empty, wr_idx only when
  // a write is actually enabled (never while full without a pop).
  always_comb begin
    top_idx = AW'(count - CW'(1));
    wr_en   = 1'b0;
    wr_idx  = AW'(count);
    if (!clear && push) begin
      if (pop && !empty) begin
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end else if (pop || !full) begin
        wr_en  = 1'b1;
      end
    end
  end

  // Combinational peek; reads as zero when nothing is stored.
  always_comb begin
    top_data = '0;
    if (!empty) top_data = stack[top_idx];
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) stack[wr_idx] <= data_in;
  end

  // Occupancy, popped data and the single-cycle status pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count     <= '0;
      data_out  <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      if (clear) begin
        count <= '0;
      end else if (push && !pop) begin
        if (full) overflow <= 1'b1;
        else      count    <= count + CW'(1);
      end else if (pop && !push) begin
        if (empty) begin
          underflow <= 1'b1;
        end else begin
          data_out  <= stack[top_idx];
          pop_valid <= 1'b1;
          count     <= count - CW'(1);
        end
      end else if (push && pop) begin
        if (empty) begin
          count     <= CW'(1);
          underflow <= 1'b1;
        end else begin
          data_out  <= stack[top_idx];
          pop_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lifo_stack_param.sv
// Scoreboard bench for lifo_stack_param: each stimulus cycle pushes the
// reference model's expected outputs into a queue; a monitor on the falling
// edge pops and compares against the DUT.
module tb_lifo_stack_param;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AFL   = 6;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clear, push, pop;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out, top_data;
  logic          pop_valid, empty, full, almost_full, overflow, underflow;
  logic [CW-1:0] count;

  lifo_stack_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_LEVEL(AFL)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .push(push), .pop(pop),
    .data_in(data_in), .data_out(data_out), .pop_valid(pop_valid),
    .top_data(top_data), .count(count), .empty(empty), .full(full),
    .almost_full(almost_full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          pv, ov, un;
    logic [DW-1:0] dout, top;
    int            cnt;
  } exp_t;

  exp_t          sbq[$];
  logic [DW-1:0] model[$];
  logic [DW-1:0] m_dout;
  int            n_checks = 0;
  int            n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: a plain queue with the stack rules applied directly.
  task automatic step(input logic c, input logic ps, input logic pp, input logic [DW-1:0] d);
    exp_t e;
    @(negedge clk);
    #1;
    clear = c; push = ps; pop = pp; data_in = d;
    e.pv = 1'b0; e.ov = 1'b0; e.un = 1'b0;
    if (c) begin
      model.delete();
    end else if (ps && !pp) begin
      if (model.size() == DEPTH) e.ov = 1'b1;
      else model.push_back(d);
    end else if (pp && !ps) begin
      if (model.size() == 0) e.un = 1'b1;
      else begin m_dout = model.pop_back(); e.pv = 1'b1; end
    end else if (ps && pp) begin
      if (model.size() == 0) begin model.push_back(d); e.un = 1'b1; end
      else begin m_dout = model[$]; model[$] = d; e.pv = 1'b1; end
    end
    e.dout = m_dout;
    e.cnt  = model.size();
    e.top  = (model.size() != 0) ? model[$] : '0;
    sbq.push_back(e);
  endtask

  // Monitor: compares one expected entry per falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("pop_valid",   32'(pop_valid),   32'(e.pv));
      chk("data_out",    32'(data_out),    32'(e.dout));
      chk("overflow",    32'(overflow),    32'(e.ov));
      chk("underflow",   32'(underflow),   32'(e.un));
      chk("count",       32'(count),       32'(e.cnt));
      chk("top_data",    32'(top_data),    32'(e.top));
      chk("empty",       32'(empty),       32'(e.cnt == 0));
      chk("full",        32'(full),        32'(e.cnt == DEPTH));
      chk("almost_full", 32'(almost_full), 32'(e.cnt >= AFL));
    end
  end

  task automatic drain();
    int budget = 5;
    while (sbq.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    #1;
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;
    m_dout = '0;
    #12;
    chk("rst_count",     32'(count),       32'd0);
    chk("rst_data_out",  32'(data_out),    32'd0);
    chk("rst_pop_valid", 32'(pop_valid),   32'd0);
    chk("rst_empty",     32'(empty),       32'd1);
    chk("rst_full",      32'(full),        32'd0);
    chk("rst_afull",     32'(almost_full), 32'd0);
    chk("rst_top",       32'(top_data),    32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Fill, overflow, drain, underflow.
    for (int i = 1; i <= 8; i++) step(0, 1, 0, DW'(i * 8'h11));
    step(0, 1, 0, 8'h99);
    step(0, 0, 0, 8'h00);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 8'h00);
    step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);

    // Replace-top, then push+pop on empty and on full.
    step(0, 1, 0, 8'hA1);
    step(0, 1, 0, 8'hA2);
    step(0, 1, 1, 8'hB0);
    step(0, 0, 1, 8'h00);
    step(0, 0, 1, 8'h00);
    step(0, 1, 1, 8'hC3);
    for (int i = 0; i < 7; i++) step(0, 1, 0, DW'(8'hD0 + i));
    step(0, 1, 1, 8'hEE);
    step(0, 0, 1, 8'h00);

    // Clear wins over a simultaneous push.
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 1, 0, DW'(8'h31 + i));
    step(1, 1, 0, 8'h5A);
    step(0, 0, 0, 8'h00);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] r;
      r = 4'($urandom_range(0, 15));
      step(r == 4'd0, 1'($urandom), 1'($urandom), DW'($urandom));
    end

    // Asynchronous reset in the middle of a cycle.
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) step(0, 1, 0, DW'(8'h61 + i));
    step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);
    drain();
    push = 1'b1; data_in = 8'h77;
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_count",     32'(count),     32'd0);
    chk("async_data_out",  32'(data_out),  32'd0);
    chk("async_empty",     32'(empty),     32'd1);
    chk("async_pop_valid", 32'(pop_valid), 32'd0);
    chk("async_top",       32'(top_data),  32'd0);
    model.delete();
    m_dout = '0;
    push = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 1, 0, 8'h42);
    step(0, 0, 1, 8'h00);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lifo_stack_param.md
Name: lifo_stack_param

Overview:
Parametrised successor to the fixed 8x8 LIFO stack, with configurable data width and depth. Adds the following over the fixed stack:
- simultaneous push+pop (replace-top)
- non-destructive peek and an occupancy count
- almost-full flag, synchronous flush
- one-cycle overflow/underflow error pulses
Flags reflect the post-operation state with no lag. Used as a scratch/return stack for datapath controllers and for ML-in-CAD benchmark designs.

Parameters:
DATA_WIDTH, 8, width of each stack entry
DEPTH, 8, number of entries; legal values are 2 or more, any integer (not restricted to powers of two)
AFULL_LEVEL, 6, almost_full asserts when count >= AFULL_LEVEL; legal range 1..DEPTH
CW, $clog2(DEPTH+1), count width (derived localparam; not overridden)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
clear  input  1  synchronous flush; empties the stack
push  input  1  push request
pop  input  1  pop request
data_in  input  DATA_WIDTH  data to push
data_out  output  DATA_WIDTH  registered popped value; holds its value between pops
pop_valid  output  1  one-cycle pulse when data_out was updated by a pop
top_data  output  DATA_WIDTH  combinational peek of the top entry; 0 when empty
count  output  CW  current occupancy, 0..DEPTH
empty  output  1  count == 0
full  output  1  count == DEPTH
almost_full  output  1  count >= AFULL_LEVEL
overflow  output  1  one-cycle pulse: a push was rejected
underflow  output  1  one-cycle pulse: a pop was rejected

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset_n=0, asynchronous): count=0, data_out=0, pop_valid=0, overflow=0, underflow=0. Storage array is not reset. After reset: empty=1, full=0, almost_full=0 (AFULL_LEVEL >= 1), top_data=0.
- count is the only state pointer. empty, full and almost_full are combinational decodes of the registered count, so they reflect the same edge that updated count.
- Per rising edge, in priority order:
  1. clear=1: count<=0, pop_valid<=0, overflow<=0, underflow<=0. push and pop are ignored. data_out holds.
  2. push & ~pop:
     - not full: stack[count]<=data_in; count<=count+1.
     - full: no change; overflow<=1.
  3. pop & ~push:
     - not empty: data_out<=stack[count-1]; pop_valid<=1; count<=count-1.
     - empty: no change; underflow<=1; data_out holds.
  4. push & pop:
     - not empty (including full): replace-top. data_out<=old stack[count-1]; pop_valid<=1; stack[count-1]<=data_in; count unchanged; no overflow.
     - empty: the push is performed (stack[0]<=data_in, count<=1); the pop is rejected (underflow<=1, pop_valid<=0).
  5. Neither push nor pop: state holds.
- pop_valid, overflow and underflow are registered and default to 0 on any edge not setting them, so each is a single-cycle pulse.
- Latency:
  - Pop: data_out is valid the cycle after the pop edge, qualified by pop_valid.
  - Push: the pushed value is visible on top_data immediately after the push edge.
- top_data = stack[count-1] when count != 0, else 0. Purely combinational; there is no read side effect.
- Arithmetic: count never wraps. Index arithmetic is done in CW bits, and count-1 is evaluated only when count != 0.
- Reset asserted mid-operation: immediate return to the reset state; any in-flight push is lost.

Test Plan:
- Reset, then push 8'h11..8'h88 on 8 consecutive edges -> count steps 1..8; almost_full rises at the edge making count=6; full=1 at count=8; top_data=8'h88; overflow stays 0.
- With the stack full, push 8'h99 for one cycle -> overflow pulses for exactly 1 cycle; count stays 8; top_data stays 8'h88.
- Pop 8 times from full -> data_out sequence 88,77,...,11, each with a 1-cycle pop_valid; empty=1 after the last pop; one further pop -> underflow pulse, data_out stays 8'h11, pop_valid=0.
- Push 8'hA1, 8'hA2, then push+pop with data_in=8'hB0 -> data_out=8'hA2 with pop_valid=1; count stays 2; top_data=8'hB0; next pop returns 8'hB0.
- On an empty stack, push+pop with data_in=8'hC3 -> count=1; top_data=8'hC3; underflow=1; pop_valid=0. Same event on a full stack -> replace-top, no overflow.
- Push 3 entries, then assert clear together with push -> count=0, empty=1, no write. Then push 5 entries and drop reset_n mid-clock -> count=0, data_out=0 asynchronously, with no clock edge needed.
